// File: rtl/traceback_unit_if.sv
// Traceback unit bus: start request, completion status, direction-memory
// read port and the emitted-direction stream.
interface traceback_unit_if #(
  parameter int IDX_W = 7
);
  logic             start;
  logic [IDX_W-1:0] start_row;
  logic [IDX_W-1:0] start_col;
  logic             busy;
  logic             done;
  logic             err;
  logic [IDX_W:0]   path_len;
  logic             dir_rd_en;
  logic [IDX_W-1:0] dir_rd_row;
  logic [IDX_W-1:0] dir_rd_col;
  logic [1:0]       dir_rd_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_dir;

  // Requester / memory / sink side
  modport master (
    output start, start_row, start_col, dir_rd_data, out_ready,
    input  busy, done, err, path_len, dir_rd_en, dir_rd_row, dir_rd_col,
           out_valid, out_dir
  );

  // Traceback engine side
  modport slave (
    input  start, start_row, start_col, dir_rd_data, out_ready,
    output busy, done, err, path_len, dir_rd_en, dir_rd_row, dir_rd_col,
           out_valid, out_dir
  );
endinterface

// File: rtl/traceback_unit.sv
// Traceback walker: starting from (row, col), repeatedly reads the direction
// matrix, emits each non-Nil direction downstream and steps toward the
// origin until a zero row/column or a Nil cell ends the walk.
module traceback_unit #(
  parameter int MAX_LEN = 64,
  parameter int IDX_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  traceback_unit_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DONE} state_t;

  localparam logic [1:0] DIR_NIL   = 2'b00;
  localparam logic [1:0] DIR_ABOVE = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DIAG  = 2'b11;
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_LEN);

  logic [1:0]       rst_sync_q;
  logic             rst_int_n;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] r_q, r_d, c_q, c_d;
  logic [IDX_W:0]   len_q, len_d;
  logic [1:0]       dir_q, dir_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] rd_row_q, rd_col_q;
  logic [1:0]       out_dir_q;

  // Reset asserts immediately but releases only after two clock edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  // Next-state and datapath: walk control and coordinate bookkeeping
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    len_d   = len_q;
    dir_d   = dir_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          r_d   = bus.start_row;
          c_d   = bus.start_col;
          len_d = '0;
          if (bus.start_row > MAX_IDX || bus.start_col > MAX_IDX) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = (bus.start_row == '0 || bus.start_col == '0) ? DONE : READ;
          end
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        dir_d   = bus.dir_rd_data;
        state_d = (bus.dir_rd_data == DIR_NIL) ? DONE : EMIT;
      end
      EMIT: begin
        if (bus.out_ready) begin
          len_d = len_q + 1'b1;
          case (dir_q)
            DIR_DIAG: begin
              r_d = r_q - 1'b1;
              c_d = c_q - 1'b1;
            end
            DIR_ABOVE: r_d = r_q - 1'b1;
            DIR_LEFT:  c_d = c_q - 1'b1;
            default: ;
          endcase
          // Stopping at a zero index is what keeps the decrements from wrapping
          state_d = (r_d == '0 || c_d == '0) ? DONE : READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so every output comes straight off a flop
  always_comb begin
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    rd_en_d     = (state_d == READ);
    out_valid_d = (state_d == EMIT);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      c_q         <= '0;
      len_q       <= '0;
      dir_q       <= DIR_NIL;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      out_valid_q <= 1'b0;
      out_dir_q   <= DIR_NIL;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      len_q       <= len_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_row_q    <= r_d;
      rd_col_q    <= c_d;
      out_valid_q <= out_valid_d;
      out_dir_q   <= dir_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.path_len   = len_q;
  assign bus.dir_rd_en  = rd_en_q;
  assign bus.dir_rd_row = rd_row_q;
  assign bus.dir_rd_col = rd_col_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_dir    = out_dir_q;

endmodule

// File: tb/tb_traceback_unit.sv
// Bench for traceback_unit: direction memory model with registered read,
// scoreboard of expected read addresses and emitted directions, a table of
// start vectors with hand-derived lengths/latencies, plus hand sequences for
// back-pressure, mid-walk reset and start-while-busy.
module tb_traceback_unit;

  localparam int MAXL = 64;
  localparam int IW   = 7;

  logic clk;
  logic rst_n;

  traceback_unit_if #(.IDX_W(IW)) bus ();

  traceback_unit #(.MAX_LEN(MAXL), .IDX_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Direction memory, one-cycle read latency
  logic [1:0] mem [0:MAXL][0:MAXL];
  logic [1:0] rd_data;
  always @(posedge clk) begin
    if (bus.dir_rd_en) rd_data <= mem[bus.dir_rd_row][bus.dir_rd_col];
  end
  assign bus.dir_rd_data = rd_data;

  typedef struct {
    int row;
    int col;
    int len;
    int err;
    int cyc;
  } vec_t;

  vec_t tbl [10];

  int nvec;
  int nfail;
  int cyc;
  int done_count;
  int done_cyc;
  int done_len;
  int done_err;
  bit beat_seen;
  int rdq[$];
  int dirq[$];

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fill_diag();
    for (int r = 0; r <= MAXL; r++)
      for (int c = 0; c <= MAXL; c++)
        mem[r][c] = 2'b11;
  endtask

  // Reference walk over the memory: expected reads and emissions
  task automatic model(input int row, input int col);
    int r;
    int c;
    logic [1:0] d;
    rdq.delete();
    dirq.delete();
    if (row > MAXL || col > MAXL) return;
    r = row;
    c = col;
    while (r != 0 && c != 0) begin
      rdq.push_back(r * 256 + c);
      d = mem[r][c];
      if (d == 2'b00) break;
      dirq.push_back(int'(d));
      if (d[0]) r--;
      if (d[1]) c--;
    end
  endtask

  // One clock: sample at the falling edge and score what the DUT shows
  task automatic step();
    int exp;
    @(negedge clk);
    cyc++;
    if (bus.dir_rd_en) begin
      check("read_expected", int'(rdq.size() != 0), 1);
      if (rdq.size() != 0) begin
        exp = rdq.pop_front();
        check("read_addr", int'(bus.dir_rd_row) * 256 + int'(bus.dir_rd_col), exp);
      end
    end
    if (bus.out_valid && !beat_seen) begin
      beat_seen = 1'b1;
      check("emit_expected", int'(dirq.size() != 0), 1);
      if (dirq.size() != 0) begin
        exp = dirq.pop_front();
        check("out_dir", int'(bus.out_dir), exp);
      end
    end else if (!bus.out_valid) begin
      beat_seen = 1'b0;
    end
    if (bus.done) begin
      done_count++;
      if (done_count == 1) begin
        done_cyc = cyc;
        done_len = int'(bus.path_len);
        done_err = int'(bus.err);
      end
    end
  endtask

  // Issue a start in the current cycle (cycle 0) and advance into cycle 1
  task automatic launch(input int row, input int col);
    model(row, col);
    done_count    = 0;
    bus.start_row = IW'(row);
    bus.start_col = IW'(col);
    bus.start     = 1'b1;
    cyc           = 0;
    step();
    bus.start = 1'b0;
    check("busy_after_start", int'(bus.busy), 1);
  endtask

  // Wait for done (bounded); optionally pulse a stray start at cycle poke
  task automatic wait_done(input int poke);
    for (int i = 0; i < 1000 && done_count == 0; i++) begin
      if (cyc == poke) begin
        bus.start     = 1'b1;
        bus.start_row = IW'(0);
        bus.start_col = IW'(5);
      end else begin
        bus.start = 1'b0;
      end
      step();
    end
    bus.start = 1'b0;
    check("done_seen", int'(done_count > 0), 1);
    step();
    step();
  endtask

  // Cycle counts are inclusive of the start cycle and the done cycle
  task automatic finish_walk(input string name, input int len, input int err, input int cycles);
    check("path_len", done_len, len);
    check("err", done_err, err);
    check("cycles", done_cyc + 1, cycles);
    check("done_pulses", done_count, 1);
    check("reads_left", rdq.size(), 0);
    check("dirs_left", dirq.size(), 0);
    check("path_len_held", int'(bus.path_len), len);
    check("busy_idle", int'(bus.busy), 0);
    $display("walk %s: path_len=%0d err=%0d cycles=%0d", name, done_len, done_err, done_cyc + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_err"}, int'(bus.err), 0);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_rd_en"}, int'(bus.dir_rd_en), 0);
    check({tag, "_path_len"}, int'(bus.path_len), 0);
    check({tag, "_out_dir"}, int'(bus.out_dir), 0);
  endtask

  initial begin
    nvec          = 0;
    nfail         = 0;
    cyc           = 0;
    done_count    = 0;
    beat_seen     = 1'b0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.start_row = '0;
    bus.start_col = '0;
    bus.out_ready = 1'b1;
    fill_diag();

    // start row, start col, path_len, err, inclusive cycles
    tbl[0] = '{3, 3, 3, 0, 11};
    tbl[1] = '{0, 5, 0, 0, 2};
    tbl[2] = '{5, 0, 0, 0, 2};
    tbl[3] = '{65, 1, 0, 1, 2};
    tbl[4] = '{1, 65, 0, 1, 2};
    tbl[5] = '{127, 127, 0, 1, 2};
    tbl[6] = '{1, 1, 1, 0, 5};
    tbl[7] = '{64, 1, 1, 0, 5};
    tbl[8] = '{64, 64, 64, 0, 194};
    tbl[9] = '{2, 7, 2, 0, 8};

    repeat (3) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) step();
    check_reset_outputs("post_release");

    // Diagonal-only matrix vectors
    foreach (tbl[i]) begin
      launch(tbl[i].row, tbl[i].col);
      wait_done(-1);
      finish_walk($sformatf("(%0d,%0d)", tbl[i].row, tbl[i].col), tbl[i].len, tbl[i].err, tbl[i].cyc);
    end

    // Mixed directions: 7 steps down to (0,0)
    mem[5][5] = 2'b01;
    mem[4][5] = 2'b10;
    mem[4][4] = 2'b11;
    mem[3][3] = 2'b10;
    mem[3][2] = 2'b01;
    mem[2][2] = 2'b11;
    launch(5, 5);
    wait_done(-1);
    finish_walk("mixed(5,5)", 7, 0, 23);

    // Left, Above, then a Nil cell stops the walk
    fill_diag();
    mem[2][2] = 2'b10;
    mem[2][1] = 2'b01;
    mem[1][1] = 2'b00;
    launch(2, 2);
    wait_done(-1);
    finish_walk("nil_stop(2,2)", 2, 0, 10);

    // Back-pressure: out_ready low for 5 clock edges while in EMIT
    fill_diag();
    bus.out_ready = 1'b0;
    launch(1, 1);
    step();
    step();
    check("stall_valid_rise", int'(bus.out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_valid", int'(bus.out_valid), 1);
      check("stall_dir", int'(bus.out_dir), 3);
      check("stall_no_read", int'(bus.dir_rd_en), 0);
      check("stall_len", int'(bus.path_len), 0);
    end
    bus.out_ready = 1'b1;
    wait_done(-1);
    finish_walk("stall(1,1)", 1, 0, 10);

    // Reset during the WAIT of the second step abandons the walk
    launch(3, 3);
    while (cyc < 5) step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midwalk");
    rdq.delete();
    dirq.delete();
    step();
    step();
    rst_n = 1'b1;
    repeat (4) step();
    check("no_done_on_reset", done_count, 0);
    launch(1, 1);
    wait_done(-1);
    finish_walk("after_reset(1,1)", 1, 0, 5);

    // Start pulsed while busy is ignored
    launch(3, 3);
    wait_done(4);
    finish_walk("start_while_busy(3,3)", 3, 0, 11);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/traceback_unit.md
TRACEBACK_UNIT -- requirements
Module: traceback_unit

Interface
REQ-001 SHALL have parameter MAX_LEN, default 64, meaning the largest legal row and column index of the score/direction matrix.
REQ-002 SHALL have parameter IDX_W, default $clog2(MAX_LEN+1), meaning the width of the row, column and length fields.
REQ-003 clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle request to begin a traceback; sampled only in IDLE.
REQ-006 start_row  input  IDX_W  starting row index; sampled with start.
REQ-007 start_col  input  IDX_W  starting column index; sampled with start.
REQ-008 busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 err  output  1  valid with done; start indices were out of range.
REQ-011 path_len  output  IDX_W+1  number of directions emitted; valid with done and held until the next accepted start.
REQ-012 dir_rd_en  output  1  direction-memory read strobe.
REQ-013 dir_rd_row, dir_rd_col  output  IDX_W each  read address, valid with dir_rd_en.
REQ-014 dir_rd_data  input  2  direction-memory data in the 2-bit direction encoding (Nil=00, Above=01, Left=10, Diagonal=11), valid exactly 1 cycle after dir_rd_en.
REQ-015 out_valid  output  1  emitted direction valid.
REQ-016 out_ready  input  1  downstream accepts out_dir.
REQ-017 out_dir  output  2  emitted direction, same encoding as dir_rd_data.

Function
REQ-018 SHALL implement the states IDLE, READ, WAIT, EMIT and DONE, with internal registers r, c (IDX_W) and len (IDX_W+1).
REQ-019 IDLE: on start=1, SHALL latch r=start_row, c=start_col and len=0; if either index exceeds MAX_LEN, go to DONE with err=1; else if r==0 or c==0, go to DONE with err=0; else go to READ.
REQ-020 READ (1 cycle): SHALL drive dir_rd_en=1, dir_rd_row=r, dir_rd_col=c, then go to WAIT.
REQ-021 WAIT (1 cycle): SHALL capture dir_rd_data; if Nil, go to DONE with no emission; else go to EMIT.
REQ-022 EMIT: SHALL drive out_valid=1 with out_dir equal to the captured direction.
REQ-023 EMIT: out_valid and out_dir SHALL stay stable until out_ready=1.
REQ-024 EMIT: out_valid SHALL NOT depend combinationally on out_ready.
REQ-025 EMIT accept (out_valid and out_ready): SHALL increment len and update r, c as Diagonal: r-1, c-1; Above: r-1; Left: c-1.
REQ-026 After the EMIT accept, if the new r==0 or c==0, SHALL go to DONE; else go to READ.
REQ-027 DONE (1 cycle): SHALL drive done=1, path_len=len, and err as determined, then go to IDLE.
REQ-028 busy SHALL be 1 in READ, WAIT, EMIT and DONE, and 0 in IDLE.
REQ-029 start while not in IDLE SHALL be ignored.
REQ-030 Outside READ, dir_rd_en SHALL be 0 and the address outputs are don't-care.
REQ-031 Outside EMIT, out_valid SHALL be 0.
REQ-032 With out_ready held high, each step SHALL take exactly 3 cycles (READ, WAIT, EMIT).
REQ-033 The total cycle count from accepted start to done SHALL be 3*path_len + 2 when the walk ends at a boundary.
REQ-034 path_len SHALL never exceed 2*MAX_LEN.
REQ-035 Decrements SHALL never underflow, because a walk ends when r==0 or c==0 before any further read.

Reset
REQ-036 rst_n low SHALL immediately force state IDLE, busy=0, done=0, err=0, out_valid=0, dir_rd_en=0, path_len=0, out_dir=Nil, and r=c=len=0.
REQ-037 Reset asserted mid-walk SHALL abandon the walk with no done pulse; after release, the block SHALL accept a new start.
REQ-038 Reset release SHALL be synchronised internally so that the first state change occurs on a clock edge.

Verification
REQ-039 Diagonal-only matrix, start (3,3), out_ready=1 -> reads at (3,3), (2,2), (1,1); out_dir Diagonal ×3; done with path_len=3, err=0, 11 cycles after start.
REQ-040 (2,2)=Left, (2,1)=Above, start (2,2) -> emits Left then Above; ends at (1,1)? No: ends at (1,1) only if a further step is taken, so the walk reads (2,2), (2,1) and then stops at (1,1)... the bench SHALL instead set (1,1)=Nil -> emissions Left, Above; read at (1,1) returns Nil; done with path_len=2.
REQ-041 start (0,5) -> no read, no emission; done 2 cycles after start with path_len=0, err=0; start (MAX_LEN+1,1) -> done with err=1, path_len=0.
REQ-042 out_ready low for 5 cycles during EMIT -> out_valid and out_dir held stable; no new read issued; len increments once on acceptance.
REQ-043 Pulse rst_n low during the WAIT of the second step -> all outputs at reset values at once; no done pulse; a fresh start (1,1) with Diagonal -> path_len=1.
REQ-044 start pulsed while busy -> ignored; the current walk's path_len is unaffected.
